// File: rtl/py_bitseq_if.sv
// Payload buffer read port of py_bitseq.
//   rd_req   : one-clock read pulse from the sequencer (master)
//   rd_addr  : byte address, valid while rd_req is high
//   rd_data  : byte returned by the buffer (slave) during the clock after rd_req
// Handshake: there is no ready. Each rd_req pulse is one request. The buffer must
// present rd_data during the clock that follows the pulse, and the sequencer
// samples it at the end of that clock.
interface py_bitseq_if #(parameter int ADDR_W = 10) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (output rd_req, output rd_addr, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_data);
endinterface

// File: rtl/py_bitseq.sv
// py_bitseq: payload bit sequencer for the BR/EDR baseband.
// Each channel-bit strobe is classified as a data, CRC, pad or parity slot.
// Supported FEC modes are none, 1/3 and (FEC_DATA,FEC_DATA+FEC_PAR).
// TX payload bytes are fetched from the payload buffer. The RX payload header
// is decoded when the build enables it.
// Optional feature macro: PY_HDR_DECODE_EN (header capture/decode).
// Ports:
//   clk_6M, rstz            clock, async active-low reset
//   start_p, abort_p        payload start / abort pulses
//   py_datvalid_p           channel-bit slot strobe
//   pylenbit, crc_en        payload bits (excluding CRC), append CRC16
//   fec_mode                00 none, 01 FEC1/3, 10 FEC2/3, 11 none
//   hdr_mode, hdr_en, rxbit header format, header present, RX info bit
//   buf_if (master)         payload buffer read port
//   py_period, info_slot, dat/crc/pad/par_phase, tx_infobit, bitcount, py_endp
//   hdr_valid_p, dec_llid, dec_flow, dec_len   decoded header fields
//   dbg_state               FSM state (0 idle, 1 run, 2 finish)
module py_bitseq #(
  parameter int LEN_W    = 13,
  parameter int FEC_DATA = 10,
  parameter int FEC_PAR  = 5,
  parameter int ADDR_W   = 10
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             start_p,
  input  logic             abort_p,
  input  logic             py_datvalid_p,
  input  logic [LEN_W-1:0] pylenbit,
  input  logic             crc_en,
  input  logic [1:0]       fec_mode,
  input  logic             hdr_mode,
  input  logic             hdr_en,
  input  logic             rxbit,
  py_bitseq_if.master      buf_if,
  output logic             py_period,
  output logic             info_slot,
  output logic             dat_phase,
  output logic             crc_phase,
  output logic             pad_phase,
  output logic             par_phase,
  output logic             tx_infobit,
  output logic [LEN_W:0]   bitcount,
  output logic             py_endp,
  output logic             hdr_valid_p,
  output logic [1:0]       dec_llid,
  output logic             dec_flow,
  output logic [9:0]       dec_len,
  output logic [1:0]       dbg_state
);

  localparam int BLK_W = $clog2(FEC_DATA + FEC_PAR);
  localparam logic [BLK_W-1:0]  BLK_DATA = BLK_W'(FEC_DATA);
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(FEC_DATA + FEC_PAR - 1);
  localparam logic [BLK_W-1:0]  BLK_ONE  = 1;
  localparam logic [LEN_W:0]    BC_ONE   = 1;
  localparam logic [LEN_W:0]    CRC_BITS = 16;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

  state_t            state;
  logic [1:0]        rep_cnt;
  logic [BLK_W-1:0]  blk_cnt;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0]        byte_reg;
  logic [LEN_W-1:0]  len_q;
  logic              crc_q;
  logic [1:0]        fec_q;

  logic [LEN_W:0] lenx, total, bc_inc;
  logic running, fec13, fec23, info_left, in_blk_data;
  logic advance, fetch, final_slot;

  assign buf_if.rd_req  = rd_req_q;
  assign buf_if.rd_addr = rd_addr_q;
  assign dbg_state      = state;

  // Configuration is latched at start, so slot classification depends only on registers.
  assign lenx        = {1'b0, len_q};
  assign total       = lenx + (crc_q ? CRC_BITS : '0);
  assign bc_inc      = bitcount + BC_ONE;
  assign running     = (state == S_RUN);
  assign fec13       = (fec_q == 2'b01);
  assign fec23       = (fec_q == 2'b10);
  assign info_left   = (bitcount < total);
  assign in_blk_data = (blk_cnt < BLK_DATA);

  assign info_slot  = running && info_left && (!fec23 || in_blk_data);
  assign pad_phase  = running && fec23 && in_blk_data && !info_left;
  assign par_phase  = running && fec23 && !in_blk_data;
  assign dat_phase  = info_slot && (bitcount < lenx);
  assign crc_phase  = info_slot && !(bitcount < lenx);
  assign tx_infobit = dat_phase && byte_reg[bitcount[2:0]];

  // An info bit is consumed on its only slot, or on the third repeat in FEC1/3.
  assign advance = py_datvalid_p && info_slot && (!fec13 || rep_cnt == 2'd2);
  // Prefetch the next byte once bit 7 goes out and data bits remain.
  assign fetch   = advance && dat_phase && (bitcount[2:0] == 3'd7) && (bc_inc < lenx);
  // FEC2/3 ends on the last parity slot after info is exhausted; other modes end on the last info bit.
  assign final_slot = fec23 ? (py_datvalid_p && running && blk_cnt == BLK_LAST && !info_left)
                            : (advance && bc_inc == total);

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state     <= S_IDLE;
      py_period <= 1'b0;
      py_endp   <= 1'b0;
      bitcount  <= '0;
      rep_cnt   <= '0;
      blk_cnt   <= '0;
      rd_req_q  <= 1'b0;
      rd_req_d  <= 1'b0;
      rd_addr_q <= '0;
      byte_reg  <= '0;
      len_q     <= '0;
      crc_q     <= 1'b0;
      fec_q     <= '0;
    end else begin
      py_endp  <= 1'b0;
      rd_req_q <= 1'b0;
      rd_req_d <= rd_req_q;
      if (rd_req_d) byte_reg <= buf_if.rd_data;
      if (abort_p) begin
        state     <= S_IDLE;
        py_period <= 1'b0;
        bitcount  <= '0;
        rep_cnt   <= '0;
        blk_cnt   <= '0;
        rd_req_d  <= 1'b0;
        rd_addr_q <= '0;
        byte_reg  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_p) begin
              if (pylenbit == '0) begin
                py_endp <= 1'b1;
              end else begin
                state     <= S_RUN;
                py_period <= 1'b1;
                len_q     <= pylenbit;
                crc_q     <= crc_en;
                fec_q     <= fec_mode;
                bitcount  <= '0;
                rep_cnt   <= '0;
                blk_cnt   <= '0;
                rd_req_q  <= 1'b1;
                rd_addr_q <= '0;
              end
            end
          end
          S_RUN: begin
            if (py_datvalid_p) begin
              if (advance) bitcount <= bc_inc;
              if (fec13 && info_slot) rep_cnt <= (rep_cnt == 2'd2) ? 2'd0 : rep_cnt + 2'd1;
              if (fec23) blk_cnt <= (blk_cnt == BLK_LAST) ? '0 : blk_cnt + BLK_ONE;
              if (fetch) begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= rd_addr_q + ADDR_ONE;
              end
              if (final_slot) begin
                py_endp <= 1'b1;
                state   <= S_FIN;
              end
            end
          end
          S_FIN: begin
            // py_endp is high during this clock; the payload window closes behind it.
            state     <= S_IDLE;
            py_period <= 1'b0;
            bitcount  <= '0;
            rep_cnt   <= '0;
            blk_cnt   <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PY_HDR_DECODE_EN
  localparam logic [LEN_W:0] HDR_BR  = 8;
  localparam logic [LEN_W:0] HDR_EDR = 16;

  logic           hdr_en_q, hdr_mode_q;
  logic [15:0]    hdr_sr, hdr_word;
  logic [LEN_W:0] hdr_bits;
  logic           hdr_cap, hdr_last;

  assign hdr_bits = hdr_mode_q ? HDR_EDR : HDR_BR;
  assign hdr_cap  = advance && hdr_en_q && (bitcount < hdr_bits) && !abort_p;
  assign hdr_last = hdr_cap && (bc_inc == hdr_bits);

  // Header bits arrive LSB first and land at their bit index.
  always_comb begin
    hdr_word = hdr_sr;
    hdr_word[bitcount[3:0]] = rxbit;
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      hdr_en_q    <= 1'b0;
      hdr_mode_q  <= 1'b0;
      hdr_sr      <= '0;
      hdr_valid_p <= 1'b0;
      dec_llid    <= '0;
      dec_flow    <= 1'b0;
      dec_len     <= '0;
    end else begin
      hdr_valid_p <= 1'b0;
      if (state == S_IDLE && start_p && !abort_p && pylenbit != '0) begin
        hdr_en_q   <= hdr_en;
        hdr_mode_q <= hdr_mode;
        hdr_sr     <= '0;
      end else if (hdr_cap) begin
        hdr_sr <= hdr_word;
        if (hdr_last) begin
          hdr_valid_p <= 1'b1;
          dec_llid    <= hdr_word[1:0];
          dec_flow    <= hdr_word[2];
          dec_len     <= hdr_mode_q ? hdr_word[12:3] : {5'b0, hdr_word[7:3]};
        end
      end
    end
  end
`else
  logic unused_hdr;
  assign unused_hdr  = ^{hdr_mode, hdr_en, rxbit};
  assign hdr_valid_p = 1'b0;
  assign dec_llid    = '0;
  assign dec_flow    = 1'b0;
  assign dec_len     = '0;
`endif

endmodule
